// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, forwarding select,
// MDU state/op, and the control bundle carried into EX/MEM.
package ex_pkg;

   // MDU codes share the 3'b100 prefix; the low two bits select the MDU op
   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_AND   = 5'd2,
      ALU_OR    = 5'd3,
      ALU_XOR   = 5'd4,
      ALU_NOR   = 5'd5,
      ALU_SLT   = 5'd6,
      ALU_SLTU  = 5'd7,
      ALU_LUI   = 5'd8,
      ALU_SLL   = 5'd9,
      ALU_SRL   = 5'd10,
      ALU_SRA   = 5'd11,
      ALU_MFHI  = 5'd12,
      ALU_MFLO  = 5'd13,
      ALU_MULT  = 5'd16,
      ALU_MULTU = 5'd17,
      ALU_DIV   = 5'd18,
      ALU_DIVU  = 5'd19
   } alu_ctl_e;

   typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB} fwd_sel_e;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_e;

   typedef enum logic [1:0] {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU} mdu_op_e;

   typedef struct packed {
      logic branch;
      logic jump;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } ex_ctl_t;

   function automatic logic is_mdu_ctl(logic [4:0] ctl);
      return ctl[4:2] == 3'b100;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: radix-2 shift-add multiplier and restoring
// divider on operand magnitudes, with sign fix-up and HI/LO writeback in DONE.
module mdu_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  mdu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   mdu_state_e      state, state_nx;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] p_hi, p_lo, opb;
   logic            is_div, neg_q, neg_r, div_zero;

   logic            sgn, a_neg, b_neg;
   logic [XLEN-1:0] ma, mb;
   logic [XLEN:0]   sum, trial;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] res_hi, res_lo;

   assign sgn   = (op == MDU_MULT) || (op == MDU_DIV);
   assign a_neg = sgn & a[XLEN-1];
   assign b_neg = sgn & b[XLEN-1];
   assign ma    = a_neg ? -a : a;
   assign mb    = b_neg ? -b : b;

   // p_hi is the running product high half / partial remainder,
   // p_lo the multiplier being consumed / quotient bits being shifted in
   assign sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opb} : '0);
   assign trial = {p_hi, p_lo[XLEN-1]} - {1'b0, opb};

   always_comb begin
      prod   = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
      if (is_div) begin
         res_hi = neg_r ? -p_hi : p_hi;
         res_lo = div_zero ? '1 : (neg_q ? -p_lo : p_lo);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = BUSY;
         BUSY:    if (cnt == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         p_hi     <= '0;
         p_lo     <= '0;
         opb      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt      <= '0;
               p_hi     <= '0;
               p_lo     <= ma;
               opb      <= mb;
               is_div   <= (op == MDU_DIV) || (op == MDU_DIVU);
               neg_q    <= a_neg ^ b_neg;
               neg_r    <= a_neg;
               div_zero <= (b == '0);
            end
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (is_div) begin
                  if (!trial[XLEN]) {p_hi, p_lo} <= {trial[XLEN-1:0], p_lo[XLEN-2:0], 1'b1};
                  else              {p_hi, p_lo} <= {p_hi[XLEN-2:0], p_lo, 1'b0};
               end else begin
                  {p_hi, p_lo} <= {sum, p_lo[XLEN-1:1]};
               end
            end
            DONE: begin
               hi <= res_hi;
               lo <= res_lo;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, ALU, iterative MDU with HI/LO,
// and the EX/MEM pipeline register. Stalls upstream while the MDU runs.
module ex_stage_mdu
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   input  logic [4:0]      alu_ctl,
   input  logic            alu_src,
   input  logic            reg_dst,
   input  logic            shift_imm,
   input  logic            branch,
   input  logic            jump,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic            reg_write,
   input  logic            mem_to_reg,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic [XLEN-1:0] imm,
   input  logic [SHW-1:0]  shamt,
   input  logic [REGW-1:0] rs_addr,
   input  logic [REGW-1:0] rt_addr,
   input  logic [REGW-1:0] rd_addr,
   input  logic [REGW-1:0] mem_rd_addr,
   input  logic [REGW-1:0] wb_rd_addr,
   input  logic            mem_reg_write,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic [XLEN-1:0] wb_fwd_data,
   input  logic            ex_flush,
   output logic            ex_stall,
   output logic            mdu_busy,
   output logic            exm_valid,
   output logic            exm_branch,
   output logic            exm_jump,
   output logic            exm_mem_read,
   output logic            exm_mem_write,
   output logic            exm_reg_write,
   output logic            exm_mem_to_reg,
   output logic            exm_zero,
   output logic [XLEN-1:0] exm_alu,
   output logic [XLEN-1:0] exm_store_data,
   output logic [REGW-1:0] exm_rd
);

   fwd_sel_e        fwd_a, fwd_b;
   logic [XLEN-1:0] a_fwd, rt_fwd, b_op, result, diff;
   logic [SHW-1:0]  shamt_eff;
   logic            is_mdu, mdu_start, mdu_done, bubble, zero;
   logic [XLEN-1:0] hi, lo;
   alu_ctl_e        op;
   ex_ctl_t         ctl_in, exm_ctl;

   always_comb begin
      fwd_a = FWD_RF;
      if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rs_addr)     fwd_a = FWD_MEM;
      else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rs_addr)   fwd_a = FWD_WB;
      fwd_b = FWD_RF;
      if (mem_reg_write && mem_rd_addr != '0 && mem_rd_addr == rt_addr)     fwd_b = FWD_MEM;
      else if (wb_reg_write && wb_rd_addr != '0 && wb_rd_addr == rt_addr)   fwd_b = FWD_WB;
   end

   always_comb begin
      case (fwd_a)
         FWD_MEM: a_fwd = mem_fwd_data;
         FWD_WB:  a_fwd = wb_fwd_data;
         default: a_fwd = rs_data;
      endcase
      case (fwd_b)
         FWD_MEM: rt_fwd = mem_fwd_data;
         FWD_WB:  rt_fwd = wb_fwd_data;
         default: rt_fwd = rt_data;
      endcase
   end

   assign b_op      = alu_src ? imm : rt_fwd;
   assign shamt_eff = shift_imm ? shamt : a_fwd[SHW-1:0];
   assign op        = alu_ctl_e'(alu_ctl);
   assign diff      = a_fwd - b_op;

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD:  result = a_fwd + b_op;
         ALU_SUB:  result = diff;
         ALU_AND:  result = a_fwd & b_op;
         ALU_OR:   result = a_fwd | b_op;
         ALU_XOR:  result = a_fwd ^ b_op;
         ALU_NOR:  result = ~(a_fwd | b_op);
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a_fwd) < $signed(b_op)};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, a_fwd < b_op};
         ALU_LUI:  result = imm << (XLEN / 2);
         ALU_SLL:  result = rt_fwd << shamt_eff;
         ALU_SRL:  result = rt_fwd >> shamt_eff;
         ALU_SRA:  result = XLEN'($signed(rt_fwd) >>> shamt_eff);
         ALU_MFHI: result = hi;
         ALU_MFLO: result = lo;
         default:  result = '0;
      endcase
   end

   assign zero = branch ? (diff == '0) : (result == '0);

   assign is_mdu    = is_mdu_ctl(alu_ctl);
   assign mdu_start = RST & in_valid & is_mdu & ~ex_flush & ~mdu_busy;

   mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk   (CLK),
      .rst_n (RST),
      .start (mdu_start),
      .op    (mdu_op_e'(alu_ctl[1:0])),
      .a     (a_fwd),
      .b     (rt_fwd),
      .busy  (mdu_busy),
      .done  (mdu_done),
      .hi    (hi),
      .lo    (lo)
   );

   // Once the MDU is running the instruction cannot be flushed; it holds
   // the stall until DONE and then retires.
   assign ex_stall = RST & in_valid & is_mdu & ~mdu_done & (mdu_busy | ~ex_flush);
   assign bubble   = ~in_valid | ex_stall | (ex_flush & ~mdu_busy);

   assign ctl_in = '{branch:     branch,
                     jump:       jump,
                     mem_read:   mem_read,
                     mem_write:  mem_write,
                     reg_write:  reg_write & ~is_mdu,
                     mem_to_reg: mem_to_reg};

   always_ff @(posedge CLK) begin
      if (!RST || bubble) begin
         exm_valid      <= 1'b0;
         exm_ctl        <= '0;
         exm_zero       <= 1'b0;
         exm_alu        <= '0;
         exm_store_data <= '0;
         exm_rd         <= '0;
      end else begin
         exm_valid      <= 1'b1;
         exm_ctl        <= ctl_in;
         exm_zero       <= zero;
         exm_alu        <= result;
         exm_store_data <= rt_fwd;
         exm_rd         <= reg_dst ? rd_addr : rt_addr;
      end
   end

   assign exm_branch     = exm_ctl.branch;
   assign exm_jump       = exm_ctl.jump;
   assign exm_mem_read   = exm_ctl.mem_read;
   assign exm_mem_write  = exm_ctl.mem_write;
   assign exm_reg_write  = exm_ctl.reg_write;
   assign exm_mem_to_reg = exm_ctl.mem_to_reg;

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed plus random checks of ex_stage_mdu at XLEN=32 and XLEN=16
// against an arithmetic reference model of the ALU and MDU.
module tb_ex_stage_mdu;
   import ex_pkg::*;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   // controls shared by both instances
   logic [4:0] alu_ctl = '0;
   logic alu_src = 0, reg_dst = 0, shift_imm = 0, branch = 0, jump = 0;
   logic mem_read = 0, mem_write = 0, reg_write = 0, mem_to_reg = 0, ex_flush = 0;
   logic [4:0] rs_addr = '0, rt_addr = '0, rd_addr = '0, mem_rd_addr = '0, wb_rd_addr = '0;
   logic mem_reg_write = 0, wb_reg_write = 0;

   // XLEN=32 instance
   logic iv = 0;
   logic [31:0] rs_d = '0, rt_d = '0, imm = '0, mem_fd = '0, wb_fd = '0;
   logic [4:0]  shamt = '0;
   logic stall, busy, e_valid, e_branch, e_jump, e_mr, e_mw, e_rw, e_m2r, e_zero;
   logic [31:0] e_alu, e_st;
   logic [4:0]  e_rd;

   // XLEN=16 instance
   logic iv16 = 0;
   logic [15:0] rs16 = '0, rt16 = '0, imm16 = '0, mem16 = '0, wb16 = '0;
   logic [3:0]  shamt16 = '0;
   logic s_stall, s_busy, s_valid, s_branch, s_jump, s_mr, s_mw, s_rw, s_m2r, s_zero;
   logic [15:0] s_alu, s_st;
   logic [4:0]  s_rd;

   ex_stage_mdu #(.XLEN(32), .REGW(5)) dut32 (
      .CLK(CLK), .RST(RST), .in_valid(iv), .alu_ctl(alu_ctl), .alu_src(alu_src),
      .reg_dst(reg_dst), .shift_imm(shift_imm), .branch(branch), .jump(jump),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .rs_data(rs_d), .rt_data(rt_d), .imm(imm),
      .shamt(shamt), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
      .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_fwd_data(mem_fd), .wb_fwd_data(wb_fd), .ex_flush(ex_flush),
      .ex_stall(stall), .mdu_busy(busy), .exm_valid(e_valid),
      .exm_branch(e_branch), .exm_jump(e_jump), .exm_mem_read(e_mr),
      .exm_mem_write(e_mw), .exm_reg_write(e_rw), .exm_mem_to_reg(e_m2r),
      .exm_zero(e_zero), .exm_alu(e_alu), .exm_store_data(e_st), .exm_rd(e_rd)
   );

   ex_stage_mdu #(.XLEN(16), .REGW(5)) dut16 (
      .CLK(CLK), .RST(RST), .in_valid(iv16), .alu_ctl(alu_ctl), .alu_src(alu_src),
      .reg_dst(reg_dst), .shift_imm(shift_imm), .branch(branch), .jump(jump),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .rs_data(rs16), .rt_data(rt16), .imm(imm16),
      .shamt(shamt16), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
      .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_fwd_data(mem16), .wb_fwd_data(wb16), .ex_flush(ex_flush),
      .ex_stall(s_stall), .mdu_busy(s_busy), .exm_valid(s_valid),
      .exm_branch(s_branch), .exm_jump(s_jump), .exm_mem_read(s_mr),
      .exm_mem_write(s_mw), .exm_reg_write(s_rw), .exm_mem_to_reg(s_m2r),
      .exm_zero(s_zero), .exm_alu(s_alu), .exm_store_data(s_st), .exm_rd(s_rd)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   logic [31:0] ra, rb, ri, er;
   logic [4:0]  rc, rsa;
   logic        rsrc, rshi;
   int          n, bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic set_alu(input logic [4:0] ctl, input logic [31:0] a, b, im,
                          input logic src, shi, input logic [4:0] sa);
      iv = 1; alu_ctl = ctl; rs_d = a; rt_d = b; imm = im;
      alu_src = src; shift_imm = shi; shamt = sa;
      reg_write = 1; reg_dst = 1; branch = 0;
      rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd4;
   endtask

   function automatic logic [31:0] alu_ref(input logic [4:0] ctl, input logic [31:0] a, rt, im,
                                           input logic src, shi, input logic [4:0] sa);
      logic [31:0] b;
      int unsigned amt;
      b   = src ? im : rt;
      amt = shi ? sa : a % 32;
      case (ctl)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_AND:  return a & b;
         ALU_OR:   return a | b;
         ALU_XOR:  return a ^ b;
         ALU_NOR:  return ~(a | b);
         ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_LUI:  return im * 32'h10000;
         ALU_SLL:  return rt << amt;
         ALU_SRL:  return rt >> amt;
         ALU_SRA:  return 32'(int'(rt) >>> amt);
         ALU_MFHI: return m_hi;
         ALU_MFLO: return m_lo;
         default:  return 32'd0;
      endcase
   endfunction

   task automatic mdu_ref(input logic [4:0] ctl, input logic [31:0] a, b,
                          output logic [31:0] h, output logic [31:0] l);
      longint p;
      longint unsigned pu;
      int sa, sb;
      sa = a; sb = b;
      h = '0; l = '0;
      case (ctl)
         ALU_MULT:  begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
         ALU_MULTU: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
         ALU_DIV: begin
            if (b == 0) begin l = '1; h = a; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin l = a; h = 0; end
            else begin l = sa / sb; h = sa % sb; end
         end
         default: begin
            if (b == 0) begin l = '1; h = a; end
            else begin l = a / b; h = a % b; end
         end
      endcase
   endtask

   // Issue one MDU op, measure the stall, check bubbles and retire, then read HI/LO.
   task automatic run_mdu(input logic [4:0] ctl, input logic [31:0] a, b);
      int cnt, bv;
      set_alu(ctl, a, b, 0, 0, 0, 0);
      #1;
      chk("issue_stall", stall, 1);
      cnt = 1; bv = 0;
      for (int i = 0; i < 100 && stall; i++) begin
         tick;
         if (e_valid) bv++;
         if (stall) cnt++;
      end
      chk("stall_cycles", cnt, 33);
      chk("stall_bubbles", bv, 0);
      chk("done_busy", busy, 1);
      mdu_ref(ctl, a, b, m_hi, m_lo);
      tick;
      chk("retire_valid", e_valid, 1);
      chk("retire_regwrite", e_rw, 0);
      set_alu(ALU_MFHI, 0, 0, 0, 0, 0, 0);
      tick;
      chk("mfhi", e_alu, m_hi);
      chk("idle_busy", busy, 0);
      set_alu(ALU_MFLO, 0, 0, 0, 0, 0, 0);
      tick;
      chk("mflo", e_alu, m_lo);
   endtask

   initial begin
      // reset
      tick; tick;
      chk("rst_valid", e_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall, 0);
      chk("rst_alu", e_alu, 0);
      RST = 1;

      // forwarding priority
      set_alu(ALU_ADD, 32'h55, 32'h66, 0, 1, 0, 0);
      rs_addr = 5'd3; rt_addr = 5'd3; mem_rd_addr = 5'd3; wb_rd_addr = 5'd3;
      mem_reg_write = 1; wb_reg_write = 1; mem_fd = 32'h11; wb_fd = 32'h22;
      tick;
      chk("fwd_mem", e_alu, 32'h11);
      chk("fwd_store", e_st, 32'h11);
      mem_reg_write = 0;
      tick;
      chk("fwd_wb", e_alu, 32'h22);
      mem_reg_write = 1; rs_addr = 0; mem_rd_addr = 0; wb_rd_addr = 0;
      tick;
      chk("fwd_r0", e_alu, 32'h55);
      mem_reg_write = 0; wb_reg_write = 0;

      // branch compare and bubbles
      set_alu(ALU_SUB, 9, 9, 0, 0, 0, 0); branch = 1;
      tick;
      chk("br_zero", e_zero, 1);
      chk("br_bit", e_branch, 1);
      rt_d = 8;
      tick;
      chk("br_nz", e_zero, 0);
      ex_flush = 1;
      tick;
      chk("flush_valid", e_valid, 0);
      chk("flush_br", e_branch, 0);
      ex_flush = 0; iv = 0;
      tick;
      chk("bubble_valid", e_valid, 0);
      chk("bubble_rw", e_rw, 0);

      // directed MDU cases
      run_mdu(ALU_MULT, -32'sd3, 32'd7);
      chk("mult_hi", m_hi, 32'hFFFFFFFF);
      chk("mult_lo", m_lo, 32'hFFFFFFEB);
      run_mdu(ALU_DIV, 32'd7, 32'd0);
      run_mdu(ALU_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_mdu(ALU_DIV, -32'sd7, 32'd2);
      chk("div_lo", m_lo, 32'hFFFFFFFD);
      run_mdu(ALU_MULTU, 32'hFFFFFFFF, 32'd2);
      chk("multu_mflo", m_lo, 32'hFFFFFFFE);

      // random MDU ops
      for (int k = 0; k < 10; k++) begin
         case ($urandom_range(0, 3))
            0: rc = ALU_MULT;
            1: rc = ALU_MULTU;
            2: rc = ALU_DIV;
            default: rc = ALU_DIVU;
         endcase
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
         run_mdu(rc, ra, rb);
      end

      // random ALU ops
      for (int k = 0; k < 24; k++) begin
         rc = 5'($urandom_range(0, 13));
         ra = $urandom; rb = $urandom; ri = $urandom;
         if (k % 4 == 0) rb = ra;
         rsrc = 1'($urandom_range(0, 1));
         rshi = 1'($urandom_range(0, 1));
         rsa  = 5'($urandom_range(0, 31));
         set_alu(rc, ra, rb, ri, rsrc, rshi, rsa);
         er = alu_ref(rc, ra, rb, ri, rsrc, rshi, rsa);
         tick;
         chk("alu_rand", e_alu, er);
         chk("alu_zero", e_zero, er == 0);
         chk("alu_rd", e_rd, 5'd4);
      end

      // reset while BUSY with counter at 10
      set_alu(ALU_MULT, 32'h1234, 32'h5678, 0, 0, 0, 0);
      repeat (11) tick;
      RST = 0; iv = 0;
      tick;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_stall", stall, 0);
      chk("rstmid_exm", {e_valid, e_branch, e_jump, e_mr, e_mw, e_rw, e_m2r, e_zero, e_alu, e_st, e_rd}, 0);
      RST = 1;
      m_hi = 0; m_lo = 0;
      set_alu(ALU_MFHI, 0, 0, 0, 0, 0, 0);
      tick;
      chk("rstmid_hi", e_alu, 0);
      set_alu(ALU_MFLO, 0, 0, 0, 0, 0, 0);
      tick;
      chk("rstmid_lo", e_alu, 0);

      // XLEN=16 instance
      iv = 0; iv16 = 1; alu_ctl = ALU_DIV; rs16 = 16'd100; rt16 = 16'd7; ex_flush = 1;
      rs_addr = 5'd1; rt_addr = 5'd2; alu_src = 0;
      #1;
      chk("x16_flush_stall", s_stall, 0);
      tick;
      chk("x16_flush_valid", s_valid, 0);
      chk("x16_flush_busy", s_busy, 0);
      ex_flush = 0; alu_ctl = ALU_SRA; rt16 = 16'h8000; shift_imm = 1; shamt16 = 4'd3;
      tick;
      chk("x16_sra", s_alu, 16'hF000);
      alu_ctl = ALU_SLL; shift_imm = 0; rs16 = 16'd17; rt16 = 16'h1234;
      tick;
      chk("x16_sll_var", s_alu, 16'h2468);
      alu_ctl = ALU_DIV; rs16 = 16'hFFF9; rt16 = 16'd2;
      #1;
      n = 1; bad = 0;
      for (int i = 0; i < 60 && s_stall; i++) begin
         tick;
         if (s_stall) n++;
         if (s_valid) bad++;
      end
      chk("x16_stall_cycles", n, 17);
      chk("x16_bubbles", bad, 0);
      tick;
      alu_ctl = ALU_MFLO;
      tick;
      chk("x16_div_lo", s_alu, 16'hFFFD);
      alu_ctl = ALU_MFHI;
      tick;
      chk("x16_div_hi", s_alu, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the five-stage pipeline, successor to the fixed 32-bit execute block. It contains the forwarding unit, the ALU, an iterative multiply/divide unit (MDU) with HI/LO registers, and the EX/MEM pipeline register. It sits between the ID/EX register and the MEM stage. While a multi-cycle MDU operation runs, it drives a stall to the hazard unit.

## Interface
- XLEN, 32: datapath width, ≥8, power of two
- REGW, 5: register-address width
- SHW, $clog2(XLEN): shift-amount width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-low reset
- in_valid  in  1  ID/EX holds a real instruction
- alu_ctl  in  5  operation code (ex_pkg encodings)
- alu_src, reg_dst, shift_imm  in  1  B = imm / dest = rd / shift by shamt
- branch, jump, mem_read, mem_write, reg_write, mem_to_reg  in  1  control bits passed to EX/MEM
- rs_data, rt_data, imm  in  XLEN  register-file operands, sign-extended immediate
- shamt  in  SHW  immediate shift amount
- rs_addr, rt_addr, rd_addr  in  REGW  source and destination register numbers
- mem_rd_addr, wb_rd_addr  in  REGW  destination registers in MEM and WB
- mem_reg_write, wb_reg_write  in  1  write enables in MEM and WB
- mem_fwd_data, wb_fwd_data  in  XLEN  forwarded values
- ex_flush  in  1  squash the current EX instruction
- ex_stall  out  1  freeze PC, IF/ID and ID/EX
- mdu_busy  out  1  MDU iterating
- exm_valid, exm_branch, exm_jump, exm_mem_read, exm_mem_write, exm_reg_write, exm_mem_to_reg, exm_zero  out  1  EX/MEM register
- exm_alu, exm_store_data  out  XLEN  result, forwarded rt
- exm_rd  out  REGW  destination register

## Operation
- **Forwarding, per operand:**
  - MEM wins if mem_reg_write, mem_rd_addr≠0 and the address matches.
  - Otherwise WB under the same rule.
  - Otherwise register-file data.
- **Operands:**
  - A = forwarded rs.
  - B = alu_src ? imm : forwarded rt.
  - exm_store_data = forwarded rt.
- **ALU ops:** ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, LUI (imm<<XLEN/2), SLL, SRL, SRA, MFHI, MFLO, MULT, MULTU, DIV, DIVU.
  - Add and subtract wrap modulo 2^XLEN; there are no overflow traps.
  - Shifts operate on forwarded rt. The amount is shamt when shift_imm, else A[SHW-1:0].
  - exm_zero = (result==0), using A−B for branch compares.
- **MDU:** radix-2 shift-add multiplier and restoring divider. Signed operations run on magnitudes and fix the sign afterwards.
  - Multiply: HI:LO = 2·XLEN-bit product.
  - Divide: LO = quotient (truncates toward zero), HI = remainder (sign of the dividend).
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed MIN/−1: LO = MIN, HI = 0.
- **MDU FSM:**
  - IDLE → BUSY on issue (in_valid & MDU op & ~ex_flush). Operands are captured on that edge, so later forwarding changes are irrelevant.
  - BUSY: counter runs 0..XLEN−1.
  - DONE: for one cycle, HI/LO are written and the instruction retires into EX/MEM with exm_reg_write=0; then → IDLE.
- ex_stall = in_valid & MDU op & ~DONE, covering the issue cycle and BUSY.
- While ex_stall=1, EX/MEM loads a bubble: all exm_* control bits and exm_valid are 0.
- ex_flush loads a bubble and suppresses an issue in the same cycle. ex_flush during BUSY is ignored.
- An MFHI/MFLO following an MDU op sees the new HI/LO, because the stall is blocking.
- A bubble (in_valid=0) propagates with all control bits 0.

## Timing
- ALU instructions: one-cycle latency, EX/MEM updates on the next edge.
- MDU op issued in cycle T:
  - ex_stall=1 in cycles T..T+XLEN.
  - DONE in cycle T+XLEN+1, with ex_stall=0.
  - HI/LO are valid from T+XLEN+2.
  - Occupancy is XLEN+2 cycles.
- mdu_busy=1 in BUSY and DONE.
- **Reset (RST=0 at an edge), including mid-operation:**
  - FSM → IDLE, counter=0, HI=LO=0.
  - All exm_* = 0.
  - ex_stall and mdu_busy are 0 from the first cycle after the reset edge.

## Structure
- Package ex_pkg holds:
  - alu_ctl encodings
  - forward-select enum (FWD_RF, FWD_MEM, FWD_WB)
  - MDU state enum (IDLE, BUSY, DONE)
- Sub-module mdu_iter (parameter XLEN) contains the FSM, counter, HI/LO and sign fix-up. Its interface is start/op/a/b in, busy/done/hi/lo out.
- Forwarding, ALU and the EX/MEM register stay inline.

## Test plan
- **Forwarding priority:** rs_addr=3, MEM and WB both write r3 with 0x11 and 0x22 → A=0x11. With mem_reg_write=0 → A=0x22. With rs_addr=0 → rf value is used.
- **Signed multiply:** MULT −3×7, XLEN=32 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. ex_stall high exactly 33 cycles, DONE in cycle T+33.
- **Divide corner cases:** DIV 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/−1 → LO=0x80000000, HI=0. DIV −7/2 → LO=−3, HI=−1.
- **MFLO after MULTU:** MULTU 0xFFFFFFFF×2 then MFLO → exm_alu=0xFFFFFFFE. EX/MEM holds bubbles (exm_valid=0) throughout the stall.
- **Reset mid-op:** RST=0 at BUSY counter=10 → next cycle mdu_busy=0, ex_stall=0, HI=LO=0, all exm_* = 0.
- **Flush, shifts and XLEN=16:** ex_flush with an issuing DIV → no stall, bubble. SRA 0x8000>>3 → 0xF000. SLL with variable amount 17 → uses amount 1.
